// File: rtl/maze_mem_arbiter_pkg.sv
// Shared types and constants for the maze cell RAM arbiter.
package maze_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 4;

  localparam logic [3:0] CELL_FLOOR  = 4'd0;
  localparam logic [3:0] CELL_WALL   = 4'd1;
  localparam logic [3:0] CELL_PLAYER = 4'd2;
  localparam logic [3:0] CELL_GOAL   = 4'd3;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_BUSY  = 2'd2;
  localparam logic [1:0] ST_ABORT = 2'd3;

  // is_wr lets a completed game write report zero read data
  typedef struct packed {
    logic valid;
    logic is_game;
    logic is_wr;
  } resp_tag_t;

endpackage

// File: rtl/maze_mem_arbiter_resp_pipe.sv
// Response tag pipeline: follows each RAM access and steers mem_rdata to
// the display or game side three cycles after the access was chosen.
module maze_resp_pipe
  import maze_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  resp_tag_t         tag_in,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              disp_valid,
  output logic [DATA_W-1:0] disp_data,
  output logic              game_ack,
  output logic [DATA_W-1:0] game_rdata
);

  resp_tag_t         s0_q, s0_d;
  resp_tag_t         s1_q, s1_d;
  logic              disp_valid_q, disp_valid_d;
  logic [DATA_W-1:0] disp_data_q, disp_data_d;
  logic              game_ack_q, game_ack_d;
  logic [DATA_W-1:0] game_rdata_q, game_rdata_d;

  // s0 lines up with mem_en on the RAM pins, s1 with mem_rdata
  always_comb begin
    s0_d         = tag_in;
    s1_d         = s0_q;
    disp_valid_d = s1_q.valid & ~s1_q.is_game;
    game_ack_d   = s1_q.valid & s1_q.is_game;
    if (disp_valid_d) begin
      disp_data_d = mem_rdata;
    end else begin
      disp_data_d = '0;
    end
    if (game_ack_d && !s1_q.is_wr) begin
      game_rdata_d = mem_rdata;
    end else begin
      game_rdata_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0_q         <= '0;
      s1_q         <= '0;
      disp_valid_q <= 1'b0;
      disp_data_q  <= '0;
      game_ack_q   <= 1'b0;
      game_rdata_q <= '0;
    end else begin
      s0_q         <= s0_d;
      s1_q         <= s1_d;
      disp_valid_q <= disp_valid_d;
      disp_data_q  <= disp_data_d;
      game_ack_q   <= game_ack_d;
      game_rdata_q <= game_rdata_d;
    end
  end

  assign disp_valid = disp_valid_q;
  assign disp_data  = disp_data_q;
  assign game_ack   = game_ack_q;
  assign game_rdata = game_rdata_q;

endmodule

// File: rtl/maze_mem_arbiter.sv
// Single-port maze RAM arbiter: display reads have strict priority, game
// accesses fill free slots (writes optionally only in vblank) with a timeout.
module maze_mem_arbiter
  import maze_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter bit WR_IN_VBLANK = 1'b1,
  parameter int TIMEOUT      = 1023
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              vblank,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic              disp_valid,
  output logic [DATA_W-1:0] disp_data,
  input  logic              game_req,
  input  logic              game_we,
  input  logic [ADDR_W-1:0] game_addr,
  input  logic [DATA_W-1:0] game_wdata,
  output logic              game_ack,
  output logic              game_err,
  output logic [DATA_W-1:0] game_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  resp_tag_t         tag_d;
  logic              game_ok_s;
  logic              pipe_game_ack_s;
  logic [DATA_W-1:0] pipe_game_rdata_s;

  assign game_ok_s = ~disp_req & (~game_we | vblank | ~WR_IN_VBLANK);

  // slot choice and game FSM; the counter only advances below CNT_MAX so it saturates
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = '0;
    mem_wdata_d = '0;
    tag_d       = '0;
    if (disp_req) begin
      mem_en_d   = 1'b1;
      mem_addr_d = disp_addr;
      tag_d      = '{valid: 1'b1, is_game: 1'b0, is_wr: 1'b0};
    end else begin
      mem_en_d = 1'b0;
    end
    case (state_q)
      ST_IDLE: begin
        if (game_req) begin
          state_d = ST_WAIT;
          cnt_d   = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (game_ok_s) begin
          state_d     = ST_BUSY;
          mem_en_d    = 1'b1;
          mem_we_d    = game_we;
          mem_addr_d  = game_addr;
          mem_wdata_d = game_we ? game_wdata : '0;
          tag_d       = '{valid: 1'b1, is_game: 1'b1, is_wr: game_we};
        end else if (cnt_q == CNT_MAX) begin
          state_d = ST_ABORT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_BUSY: begin
        if (pipe_game_ack_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_BUSY;
        end
      end
      ST_ABORT: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  maze_resp_pipe #(.DATA_W(DATA_W)) u_resp_pipe (
    .clk        (clk),
    .rst_n      (rst_n),
    .tag_in     (tag_d),
    .mem_rdata  (mem_rdata),
    .disp_valid (disp_valid),
    .disp_data  (disp_data),
    .game_ack   (pipe_game_ack_s),
    .game_rdata (pipe_game_rdata_s)
  );

  // ABORT lasts exactly the error cycle and never overlaps a pipe ack
  assign game_ack   = pipe_game_ack_s | (state_q == ST_ABORT);
  assign game_err   = (state_q == ST_ABORT);
  assign game_rdata = pipe_game_rdata_s;
  assign mem_en     = mem_en_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_maze_mem_arbiter.sv
// Randomized scoreboard bench for maze_mem_arbiter with a cycle-level
// transaction model and a behavioural RAM attached to the mem_* port.
module tb_maze_mem_arbiter;

  localparam int AW = 8;
  localparam int DW = 4;
  localparam int TO = 15;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          vblank, disp_req, game_req, game_we;
  logic [AW-1:0] disp_addr, game_addr, mem_addr;
  logic [DW-1:0] game_wdata, disp_data, game_rdata, mem_wdata, mem_rdata;
  logic          disp_valid, game_ack, game_err, mem_en, mem_we;

  always #5 clk = ~clk;

  maze_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WR_IN_VBLANK(1'b1), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .vblank(vblank),
    .disp_req(disp_req), .disp_addr(disp_addr), .disp_valid(disp_valid), .disp_data(disp_data),
    .game_req(game_req), .game_we(game_we), .game_addr(game_addr), .game_wdata(game_wdata),
    .game_ack(game_ack), .game_err(game_err), .game_rdata(game_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  typedef struct { int cyc; logic [DW-1:0] data; } disp_exp_t;
  typedef struct { int cyc; logic err; logic [DW-1:0] data; } game_exp_t;
  typedef struct { int cyc; logic we; logic [AW-1:0] addr; logic [DW-1:0] wdata; } mem_exp_t;

  disp_exp_t disp_q[$];
  game_exp_t game_q[$];
  mem_exp_t  mem_q[$];

  logic [DW-1:0] ram [256];
  logic [DW-1:0] model_mem [256];
  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;

  // game transaction model: 0 none, 1 waiting, 2 issued/aborted awaiting ack
  int   g_phase = 0;
  int   g_start = 0;
  int   g_ack_cyc = 0;
  logic g_err = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata <= ram[mem_addr];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_disp_valid"}, 32'(disp_valid), 32'd0);
    check({tag, "_disp_data"},  32'(disp_data),  32'd0);
    check({tag, "_game_ack"},   32'(game_ack),   32'd0);
    check({tag, "_game_err"},   32'(game_err),   32'd0);
    check({tag, "_game_rdata"}, 32'(game_rdata), 32'd0);
    check({tag, "_mem_en"},     32'(mem_en),     32'd0);
    check({tag, "_mem_we"},     32'(mem_we),     32'd0);
    check({tag, "_mem_addr"},   32'(mem_addr),   32'd0);
    check({tag, "_mem_wdata"},  32'(mem_wdata),  32'd0);
  endtask

  // monitor: compares every cycle against whatever the model scheduled for it
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (disp_q.size() > 0 && disp_q[0].cyc == cyc) begin
        check("disp_valid", 32'(disp_valid), 32'd1);
        check("disp_data", 32'(disp_data), 32'(disp_q[0].data));
        void'(disp_q.pop_front());
      end else begin
        check("disp_spurious", 32'(disp_valid), 32'd0);
      end
      if (game_q.size() > 0 && game_q[0].cyc == cyc) begin
        check("game_ack", 32'(game_ack), 32'd1);
        check("game_err", 32'(game_err), 32'(game_q[0].err));
        check("game_rdata", 32'(game_rdata), 32'(game_q[0].data));
        void'(game_q.pop_front());
      end else begin
        check("game_spurious", 32'({game_ack, game_err}), 32'd0);
      end
      if (mem_q.size() > 0 && mem_q[0].cyc == cyc) begin
        check("mem_en", 32'(mem_en), 32'd1);
        check("mem_we", 32'(mem_we), 32'(mem_q[0].we));
        check("mem_addr", 32'(mem_addr), 32'(mem_q[0].addr));
        if (mem_q[0].we) check("mem_wdata", 32'(mem_wdata), 32'(mem_q[0].wdata));
        void'(mem_q.pop_front());
      end else begin
        check("mem_spurious", 32'(mem_en), 32'd0);
      end
    end
  end

  // one cycle of stimulus plus the expected consequences under the arbitration rules
  task automatic step(input int p_disp, input int p_vb, input int p_game);
    int c;
    @(posedge clk);
    #2;
    c = cyc;
    disp_req  = ($urandom_range(99) < p_disp);
    disp_addr = AW'($urandom);
    vblank    = ($urandom_range(99) < p_vb);
    if (disp_req) begin
      disp_q.push_back('{cyc: c + 3, data: model_mem[disp_addr]});
      mem_q.push_back('{cyc: c + 1, we: 1'b0, addr: disp_addr, wdata: '0});
    end
    case (g_phase)
      0: begin
        if ($urandom_range(99) < p_game) begin
          game_req   = 1'b1;
          game_we    = 1'($urandom_range(1));
          game_addr  = AW'($urandom);
          game_wdata = DW'($urandom);
          g_phase    = 1;
          g_start    = c + 1;
        end else begin
          game_req = 1'b0;
        end
      end
      1: begin
        if (!disp_req && (!game_we || vblank)) begin
          if (game_we) begin
            model_mem[game_addr] = game_wdata;
            game_q.push_back('{cyc: c + 3, err: 1'b0, data: '0});
          end else begin
            game_q.push_back('{cyc: c + 3, err: 1'b0, data: model_mem[game_addr]});
          end
          mem_q.push_back('{cyc: c + 1, we: game_we, addr: game_addr, wdata: game_wdata});
          g_phase = 2; g_ack_cyc = c + 3; g_err = 1'b0;
        end else if (c - g_start == TO) begin
          game_q.push_back('{cyc: c + 1, err: 1'b1, data: '0});
          g_phase = 2; g_ack_cyc = c + 1; g_err = 1'b1;
        end
      end
      default: begin
        if (c == g_ack_cyc) g_phase = 0;
      end
    endcase
  endtask

  task automatic run(input int n, input int p_disp, input int p_vb, input int p_game);
    for (int i = 0; i < n; i++) step(p_disp, p_vb, p_game);
  endtask

  initial begin
    bit found;
    rst_n = 1'b0; vblank = 1'b0; disp_req = 1'b0; disp_addr = '0;
    game_req = 1'b0; game_we = 1'b0; game_addr = '0; game_wdata = '0;
    for (int i = 0; i < 256; i++) begin
      ram[i] = DW'($urandom);
      model_mem[i] = ram[i];
    end
    #3;
    check_all_zero("reset");
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;

    run(600, 40, 50, 30);
    run(80, 100, 50, 100);
    run(200, 10, 0, 60);
    run(200, 50, 100, 60);

    // reset while a game access sits in BUSY, after its RAM access has landed
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      step(30, 50, 60);
      if (g_phase == 2 && !g_err && cyc == g_ack_cyc - 1) found = 1'b1;
    end
    check("reset_setup_found", 32'(found), 32'd1);
    if (found) begin
      #1 rst_n = 1'b0;
      #1 check_all_zero("midop_reset");
      disp_req = 1'b0; game_req = 1'b0;
      disp_q.delete(); game_q.delete(); mem_q.delete();
      g_phase = 0;
      repeat (3) @(posedge clk);
      #3 rst_n = 1'b1;
    end

    run(300, 40, 50, 40);
    run(60, 0, 100, 0);
    check("drain_disp_q", 32'(disp_q.size()), 32'd0);
    check("drain_game_q", 32'(game_q.size()), 32'd0);
    check("drain_mem_q",  32'(mem_q.size()),  32'd0);
    check("drain_game_idle", 32'(g_phase), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
